// File: rtl/adc_frame_collector.sv
// adc_frame_collector
//   Collects one averaged ADC result per electrode step into a small result
//   buffer. Each step_done pulse starts a step: wait SETTLE_CYCLES for the
//   analog path to settle, take 2^AVG_LOG2 conversions one at a time, then
//   store the truncated mean at buffer[step_idx]. frame_done pulses once the
//   last step of a frame (index NUM_STEPS-1) has been stored.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (also clears the result buffer)
//   step_done   one-cycle pulse: mux/DAC are set, tmux_ctrl holds the step index
//   tmux_ctrl   step index, sampled with step_done
//   adc_start   one-cycle conversion request to the ADC interface
//   adc_valid   one-cycle strobe qualifying adc_data
//   adc_data    unsigned ADC sample
//   rd_addr     result buffer read address
//   rd_data     registered buffer[rd_addr]
//   busy        high whenever the FSM is not in IDLE
//   frame_done  one-cycle pulse in the cycle after the last step is stored
//   overrun     sticky: step_done arrived while busy (cleared only by rst)
module adc_frame_collector #(
  parameter int SETTLE_CYCLES = 8,
  parameter int AVG_LOG2      = 2,
  parameter int ADC_W         = 16,
  parameter int NUM_STEPS     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_done,
  input  logic [3:0]       tmux_ctrl,
  output logic             adc_start,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  input  logic [3:0]       rd_addr,
  output logic [ADC_W-1:0] rd_data,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] NSAMP     = CNT_W'(1 << AVG_LOG2);
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYCLES);
  localparam logic [4:0]       NSTEP5    = 5'(NUM_STEPS);
  localparam logic [4:0]       LAST5     = 5'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    STORE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [3:0]         step_idx_q, step_idx_d;
  logic               start_req_q, start_req_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;
  logic [ADC_W-1:0]   rd_data_q, rd_data_d;
  logic [ADC_W-1:0]   mem_q [NUM_STEPS];
  logic               wr_en;
  logic [ADC_W-1:0]   wr_data;

  // Mean of the accumulated samples, truncated toward zero.
  function automatic logic [ADC_W-1:0] avg_trunc(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1:AVG_LOG2];
  endfunction

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    step_idx_d   = step_idx_q;
    start_req_d  = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    wr_en        = 1'b0;
    wr_data      = avg_trunc(acc_q);
    adc_start    = 1'b0;
    cnt_inc      = cnt_q + 1'b1;

    // STORE is not IDLE, so a step_done in the returning cycle is an overrun too.
    if (step_done && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (step_done) begin
          step_idx_d = tmux_ctrl;
          acc_d      = '0;
          cnt_d      = '0;
          settle_d   = SETTLE_LD;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          adc_start = 1'b1;
          state_d   = CONVERT;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      CONVERT: begin
        // Next request goes out the cycle after a sample lands, so only one
        // conversion is ever outstanding.
        adc_start = start_req_q;
        if (adc_valid) begin
          acc_d = acc_q + ACC_W'(adc_data);
          cnt_d = cnt_inc;
          if (cnt_inc < NSAMP) begin
            start_req_d = 1'b1;
          end else begin
            state_d = STORE;
          end
        end
      end
      STORE: begin
        // Out-of-range step indices run the full sequence but never write.
        wr_en        = ({1'b0, step_idx_q} < NSTEP5);
        frame_done_d = ({1'b0, step_idx_q} == LAST5);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_data_d = ({1'b0, rd_addr} < NSTEP5) ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      step_idx_q   <= '0;
      start_req_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= '0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      step_idx_q   <= step_idx_d;
      start_req_q  <= start_req_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      // Read samples the pre-write contents: same-address read returns old data.
      rd_data_q    <= rd_data_d;
      if (wr_en) begin
        mem_q[step_idx_q] <= wr_data;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_adc_frame_collector.sv
module tb_adc_frame_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_done = 1'b0;
  logic [3:0]  tmux_ctrl = 4'd0;
  logic        adc_start;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_data = 16'd0;
  logic [3:0]  rd_addr = 4'd0;
  logic [15:0] rd_data;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  adc_frame_collector dut (
    .clk        (clk),
    .rst        (rst),
    .step_done  (step_done),
    .tmux_ctrl  (tmux_ctrl),
    .adc_start  (adc_start),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] val;
    logic        fd;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] samp_q [$];
  logic [15:0] mem_m [16];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int first_start = -1;
  int n_fd = 0;
  int fell_cyc = -1;
  int inj = 0;
  logic last_busy = 1'b0;
  logic fell = 1'b0;
  logic d0 = 1'b0;
  logic d1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock: observe outputs of the current cycle at the falling edge, then
  // drive the ADC model (2-cycle start->valid latency) for this cycle.
  task tick();
    @(negedge clk);
    cyc++;
    if (adc_start) begin
      n_start++;
      if (first_start < 0) first_start = cyc;
    end
    if (frame_done) n_fd++;
    fell = last_busy && !busy;
    if (fell) fell_cyc = cyc;
    last_busy = busy;
    if (inj > 0) begin
      adc_valid = 1'b1;
      adc_data  = 16'h7777;
      inj--;
    end else if (d1) begin
      adc_valid = 1'b1;
      adc_data  = (samp_q.size() > 0) ? samp_q.pop_front() : 16'd0;
    end else begin
      adc_valid = 1'b0;
      adc_data  = 16'd0;
    end
    d1 = d0;
    d0 = adc_start;
  endtask

  task rd_chk(input logic [3:0] idx, input string tag);
    rd_addr = idx;
    tick();
    chk(tag, rd_data, mem_m[idx]);
  endtask

  // Runs one step; ov_at >= 0 injects a second step_done (index 9) that many
  // cycles after the first, while the block is busy.
  task run_step(input logic [3:0] idx, input logic [15:0] s0, input logic [15:0] s1,
                input logic [15:0] s2, input logic [15:0] s3, input int ov_at);
    int   sum;
    int   sd_cyc;
    logic done;
    exp_t e;
    sum = int'(s0) + int'(s1) + int'(s2) + int'(s3);
    samp_q.push_back(s0);
    samp_q.push_back(s1);
    samp_q.push_back(s2);
    samp_q.push_back(s3);
    exp_q.push_back('{idx: idx, val: 16'(sum >> 2), fd: (idx == 4'd15)});
    n_start     = 0;
    first_start = -1;
    step_done   = 1'b1;
    tmux_ctrl   = idx;
    sd_cyc      = cyc;
    tick();
    step_done = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      if (t == ov_at) begin
        step_done = 1'b1;
        tmux_ctrl = 4'd9;
      end
      tick();
      step_done = 1'b0;
      if (fell) done = 1'b1;
    end
    if (!done) chk("step_timeout", 32'd0, 32'd1);
    e = exp_q.pop_front();
    chk("frame_done_at_idle", frame_done, e.fd);
    chk("start_latency", first_start - sd_cyc, 9);
    chk("start_count", n_start, 4);
    chk("busy_fall", fell_cyc - sd_cyc, 22);
    mem_m[e.idx] = e.val;
    rd_chk(e.idx, "buf_after_step");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = 16'd0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_adc_start", adc_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rd_data", rd_data, 0);

    // Step 3: 100,200,300,400 -> 250, no frame_done
    n_fd = 0;
    run_step(4'd3, 16'd100, 16'd200, 16'd300, 16'd400, -1);
    chk("step3_val", rd_data, 250);
    chk("step3_no_fd", n_fd, 0);
    chk("step3_overrun", overrun, 0);

    // Full frame at full scale: no accumulator overflow, one frame_done
    n_fd = 0;
    for (int s = 0; s < 16; s++) begin
      run_step(4'(s), 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1);
    end
    tick();
    chk("frame_fd_count", n_fd, 1);
    for (int s = 0; s < 16; s++) rd_chk(4'(s), "frame_buf");
    chk("frame_entry_lit", rd_data, 16'hFFFF);

    // Truncation: 1,1,1,2 -> 1
    run_step(4'd2, 16'd1, 16'd1, 16'd1, 16'd2, -1);
    chk("trunc_val", rd_data, 1);

    // Stray adc_valid in IDLE must not reach the accumulator
    inj = 3;
    repeat (5) tick();
    run_step(4'd4, 16'd8, 16'd8, 16'd8, 16'd12, -1);
    chk("idle_valid_val", rd_data, 9);

    // Overrun during SETTLE of step 5
    run_step(4'd5, 16'd10, 16'd20, 16'd30, 16'd40, 2);
    chk("ovr_flag", overrun, 1);
    chk("ovr_step5_val", rd_data, 25);
    rd_chk(4'd9, "ovr_idx9_untouched");
    run_step(4'd7, 16'd1000, 16'd2000, 16'd3000, 16'd4000, -1);
    chk("ovr_sticky", overrun, 1);

    // Reset during CONVERT of step 15
    samp_q.push_back(16'd50);
    samp_q.push_back(16'd50);
    samp_q.push_back(16'd50);
    samp_q.push_back(16'd50);
    step_done = 1'b1;
    tmux_ctrl = 4'd15;
    tick();
    step_done = 1'b0;
    repeat (12) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    samp_q.delete();
    d0 = 1'b0;
    d1 = 1'b0;
    n_fd = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 16'd0;
    tick();
    chk("post_rst_adc_start", adc_start, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_overrun", overrun, 0);
    repeat (4) tick();
    chk("post_rst_no_fd", n_fd, 0);
    for (int s = 0; s < 16; s++) rd_chk(4'(s), "post_rst_buf");
    run_step(4'd15, 16'd4, 16'd4, 16'd4, 16'd5, -1);
    chk("post_rst_step_val", rd_data, 4);
    chk("post_rst_fd", n_fd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_frame_collector.md
ADC_FRAME_COLLECTOR -- requirements
Module: adc_frame_collector

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 8, meaning the number of idle cycles after step_done before the first ADC conversion.
REQ-002 The block SHALL have parameter AVG_LOG2, default 2, meaning log2 of the number of samples averaged per step (4 samples).
REQ-003 The block SHALL have parameter ADC_W, default 16, meaning the ADC sample width and the stored result width.
REQ-004 The block SHALL have parameter NUM_STEPS, default 16, meaning the number of steps per frame.
REQ-005 Port clk SHALL be an input, 1 bit wide: the single clock, rising edge.
REQ-006 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-007 Port step_done SHALL be an input, 1 bit wide: one-cycle pulse from the step controller indicating that the electrode mux and DAC are set for a step.
REQ-008 Port tmux_ctrl SHALL be an input, 4 bits wide: step index, sampled in the step_done cycle.
REQ-009 Port adc_start SHALL be an output, 1 bit wide: one-cycle conversion request to the ADC interface.
REQ-010 Port adc_valid SHALL be an input, 1 bit wide: one-cycle strobe indicating that adc_data is valid.
REQ-011 Port adc_data SHALL be an input, ADC_W bits wide: unsigned sample.
REQ-012 Port rd_addr SHALL be an input, 4 bits wide: result buffer read address.
REQ-013 Port rd_data SHALL be an output, ADC_W bits wide: buffer[rd_addr], registered.
REQ-014 Port busy SHALL be an output, 1 bit wide: high in every state except IDLE.
REQ-015 Port frame_done SHALL be an output, 1 bit wide: one-cycle pulse after the last step of a frame is stored.
REQ-016 Port overrun SHALL be an output, 1 bit wide: sticky flag, set when step_done arrives while busy.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, SETTLE, CONVERT and STORE.
REQ-018 In IDLE, when step_done=1, the block SHALL latch tmux_ctrl into step_idx, clear the accumulator and sample count, load the settle counter with SETTLE_CYCLES, and go to SETTLE.
REQ-019 In SETTLE, the settle counter SHALL decrement once per cycle; at 0, the block SHALL assert adc_start for one cycle and go to CONVERT, so the first adc_start occurs exactly SETTLE_CYCLES+1 cycles after the step_done cycle; SETTLE_CYCLES=0 SHALL give adc_start 1 cycle after step_done.
REQ-020 In CONVERT, each adc_valid SHALL add adc_data to an accumulator of ADC_W+AVG_LOG2 bits with no overflow and increment the sample count; if the count is still below 2^AVG_LOG2, adc_start SHALL pulse in the next cycle; otherwise the block SHALL go to STORE.
REQ-021 At most one adc_start SHALL be outstanding at a time, and adc_valid SHALL be ignored outside CONVERT.
REQ-022 CONVERT SHALL have no timeout and SHALL wait indefinitely for adc_valid.
REQ-023 In STORE, for one cycle, the block SHALL write accumulator >> AVG_LOG2 (truncating) to buffer[step_idx] and then return to IDLE.
REQ-024 If step_idx = NUM_STEPS-1, frame_done SHALL be high in the cycle following STORE.
REQ-025 A step_idx >= NUM_STEPS SHALL be processed but its write SHALL be suppressed, and it SHALL not generate frame_done.
REQ-026 A step_done while busy=1 SHALL be ignored, SHALL not disturb the current step, and SHALL set overrun.
REQ-027 overrun SHALL clear only on rst.
REQ-028 A step_done in the same cycle the block returns to IDLE (the STORE cycle) SHALL count as busy, and SHALL therefore be ignored and set overrun.
REQ-029 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is presented.
REQ-030 A read and a write to the same address in the same cycle SHALL return the old value.
REQ-031 The buffer SHALL be NUM_STEPS x ADC_W; entries SHALL be overwritten by each frame and never cleared by the FSM.

Reset
REQ-032 On rst=1 at a clock edge, the FSM SHALL go to IDLE and the accumulator, counters and step_idx SHALL clear to 0.
REQ-033 On reset, adc_start, busy, frame_done and overrun SHALL be 0, and rd_data SHALL be 0 in the cycle after reset.
REQ-034 Reset SHALL clear all buffer entries to 0.
REQ-035 Reset asserted mid-step SHALL abort the step with no buffer write and no frame_done; after reset, the first step_done SHALL start a fresh step normally.

Verification
REQ-036 The bench SHALL check: step_done with tmux_ctrl=3, ADC returning 100, 200, 300, 400 with 2-cycle latency -> adc_start first at +9 cycles, exactly 4 adc_start pulses, buffer[3]=250, busy falls after STORE, no frame_done.
REQ-037 The bench SHALL check: 16 steps with tmux_ctrl=0..15 and constant adc_data=0xFFFF -> all entries 0xFFFF (no accumulator overflow), and exactly one frame_done, one cycle after the step-15 STORE.
REQ-038 The bench SHALL check: samples 1, 1, 1, 2 -> stored value 1 (truncation).
REQ-039 The bench SHALL check: a second step_done during SETTLE of step 5 -> overrun=1, step 5 completes unchanged, no extra adc_start; overrun stays 1 until rst.
REQ-040 The bench SHALL check: rst during CONVERT of step 15 -> no write and no frame_done; buffer all 0; adc_start=0 in the cycle after reset; the next step_done then runs normally.
REQ-041 The bench SHALL check: adc_valid pulses injected while in IDLE -> accumulator unaffected, and the following step stores the correct average.
